elastic_skid_buffer: RTL and testbench

Parametrised ready/valid elastic buffer with a registered upstream ready, for cutting the combinational ready path between pipeline stages. It generalises the single-entry registered-ready stage to DEPTH entries of DATA_W-bit payload, with an optional output register, occupancy reporting and a synchronous flush. It sits between any producer and consumer using the valid/ready handshake.

---
 rtl/elastic_skid_buffer.sv | 157 +++++++++++++++
 tb/tb_elastic_skid_buffer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/elastic_skid_buffer.sv
// elastic_skid_buffer
//   Ready/valid elastic buffer with DEPTH entries and a registered upstream
//   ready. Cuts the combinational ready path between two pipeline stages:
//   o_ready is a flop and never looks at i_ready in the same cycle.
//
//   Parameters
//     DATA_W     payload width in bits (>=1)
//     DEPTH      storage entries (power of 2, >=2)
//     OPT_OUTREG 1: head word held in a dedicated output flop
//                0: o_data is the entry array read at the read pointer
//
//   Ports
//     i_clk    clock, rising edge
//     i_reset  synchronous active-high reset
//     i_flush  synchronous flush, drops all stored words
//     i_valid  upstream word valid
//     i_data   upstream payload
//     o_ready  registered; buffer accepts a word this cycle
//     o_valid  registered; o_data holds a valid word
//     o_data   head-of-buffer payload
//     i_ready  downstream accepts o_data this cycle
//     o_count  registered occupancy, 0..DEPTH
module elastic_skid_buffer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter bit OPT_OUTREG = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_valid,
    input  logic [DATA_W-1:0]            i_data,
    output logic                         o_ready,
    output logic                         o_valid,
    output logic [DATA_W-1:0]            o_data,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("elastic_skid_buffer: DEPTH must be a power of 2 and >= 2");
        end
        if (DATA_W < 1) begin : g_bad_width
            $error("elastic_skid_buffer: DATA_W must be >= 1");
        end
    endgenerate

    logic              push;
    logic              pop;
    logic [CW-1:0]     count_next;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    always_comb begin
        count_next = o_count;
        if (push && !pop)
            count_next = o_count + ONE_C;
        else if (!push && pop)
            count_next = o_count - ONE_C;
    end

    // Occupancy and both handshake flags come from the same next-count value,
    // so full/empty never depend on pointer comparison.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_count <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b0;
        end else if (i_flush) begin
            o_count <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            o_count <= count_next;
            o_valid <= (count_next != '0);
            o_ready <= (count_next < DEPTH_C);
        end
    end

    generate
        if (OPT_OUTREG) begin : g_outreg
            // The head word lives in out_q; the array only holds the words
            // queued behind it, so it is empty whenever o_count <= 1.
            logic [DATA_W-1:0] out_q;
            logic              mem_empty;
            logic              head_free;
            logic              mem_wr;

            assign mem_empty = (o_count <= ONE_C);
            // Head slot is free if nothing is shown, or the shown word leaves
            // this cycle with nothing behind it.
            assign head_free = !o_valid || (pop && mem_empty);
            assign mem_wr    = push && !head_free;

            always_ff @(posedge i_clk) begin
                if (!i_reset && !i_flush && mem_wr)
                    mem[wptr] <= i_data;
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    wptr  <= '0;
                    rptr  <= '0;
                    out_q <= '0;
                end else if (i_flush) begin
                    wptr  <= '0;
                    rptr  <= '0;
                end else begin
                    if (mem_wr)
                        wptr <= wptr + 1'b1;
                    // pop with a non-empty array and push into a free head
                    // are mutually exclusive, so one load source per cycle.
                    if (pop && !mem_empty) begin
                        out_q <= mem[rptr];
                        rptr  <= rptr + 1'b1;
                    end else if (push && head_free) begin
                        out_q <= i_data;
                    end
                end
            end

            assign o_data = out_q;
        end else begin : g_mux
            always_ff @(posedge i_clk) begin
                if (!i_reset && !i_flush && push)
                    mem[wptr] <= i_data;
            end

            always_ff @(posedge i_clk) begin
                if (i_reset || i_flush) begin
                    wptr <= '0;
                    rptr <= '0;
                end else begin
                    if (push)
                        wptr <= wptr + 1'b1;
                    if (pop)
                        rptr <= rptr + 1'b1;
                end
            end

            // Gate with o_valid so the unreset array never leaks onto o_data
            // after reset.
            assign o_data = o_valid ? mem[rptr] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_elastic_skid_buffer.sv
// Scoreboard bench: both OPT_OUTREG variants run side by side on identical
// stimulus. The stimulus task pushes accepted words into an expected queue;
// the monitor checks handshake/occupancy every cycle and pops on transfers.
module tb_elastic_skid_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          valid = 1'b0;
    logic          rdy = 1'b0;
    logic [DW-1:0] din = '0;

    logic [1:0]    ordy;
    logic [1:0]    ov;
    logic [DW-1:0] od [2];
    logic [CW-1:0] oc [2];

    always #5 clk = ~clk;

    elastic_skid_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .OPT_OUTREG(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid), .i_data(din),
        .o_ready(ordy[0]), .o_valid(ov[0]), .o_data(od[0]), .i_ready(rdy), .o_count(oc[0])
    );

    elastic_skid_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .OPT_OUTREG(1'b1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid), .i_data(din),
        .o_ready(ordy[1]), .o_valid(ov[1]), .o_data(od[1]), .i_ready(rdy), .o_count(oc[1])
    );

    logic [DW-1:0] q [$];
    logic          exp_ready = 1'b0;
    logic          exp_zero  = 1'b1;
    logic          chk_en    = 1'b0;
    int            errs   = 0;
    int            checks = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s dut%0d got=%h expected=%h at %0t", nm, k, got, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, inputs are stable here.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("valid", k, 32'(ov[k]), 32'(q.size() != 0));
                chk("ready", k, 32'(ordy[k]), 32'(exp_ready));
                chk("count", k, 32'(oc[k]), 32'(q.size()));
                if (q.size() != 0)
                    chk("data", k, 32'(od[k]), 32'(q[0]));
                else if (exp_zero)
                    chk("rst_data", k, 32'(od[k]), 32'd0);
            end
            if (q.size() != 0 && rdy)
                void'(q.pop_front());
        end
    end

    // One clock of stimulus; updates the expected model after the monitor ran.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic rs, output logic acc);
        valid = v; din = d; rdy = r; flush = f; rst = rs;
        @(negedge clk);
        #1;
        acc = v && exp_ready && !f && !rs;
        if (rs) begin
            q.delete();
            exp_ready = 1'b0;
            exp_zero  = 1'b1;
        end else begin
            exp_zero = 1'b0;
            if (f) begin
                q.delete();
                exp_ready = 1'b1;
            end else begin
                if (acc) q.push_back(d);
                exp_ready = (q.size() < DEPTH);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, 1'b0, 1'b0, a);
    endtask

    initial begin
        logic          a;
        int            idx;
        logic [DW-1:0] w;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);   // reset state checked next
        idle(2, 1'b1);

        // back-to-back with downstream always ready
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, a);
        idle(3, 1'b1);

        // fill to full under stall, hold A4 at input, then drain
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            w = 8'hA0 + 8'(idx);
            step(1'b1, w, (c >= 6), 1'b0, 1'b0, a);
            if (a) idx++;
        end
        if (idx != 6) chk("fill_bound", 0, 32'(idx), 32'd6);
        idle(8, 1'b1);

        // count 3, push and pop in the same cycle
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, a);
        idle(6, 1'b1);

        // count 2, flush with a coincident push of 0x77
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, a);
        idle(4, 1'b1);

        // reset mid-stream with count 3
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h63, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 8'h64, 1'b0, 1'b0, 1'b1, a);
        idle(3, 1'b1);
        step(1'b1, 8'h65, 1'b1, 1'b0, 1'b0, a);
        idle(3, 1'b1);

        // random traffic, both variants against the same scoreboard
        for (int c = 0; c < 10000; c++) begin
            w = 8'($urandom);
            step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 199) == 0), 1'b0, a);
        end
        idle(8, 1'b1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
